// File: rtl/run_dump_ctrl.sv
// rtl/run_dump_ctrl.sv - run controller: hold core in reset, run a bounded cycle budget, then dump the register file
// Outputs are decoded from state, except the counter and dump registers.

module run_dump_ctrl #(
  parameter int unsigned RUN_CYCLES = 100,
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              halt_i,
  output logic              cpu_rst_o,
  output logic              cpu_en_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [31:0]       cycle_cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RUN  = 3'd2,
    S_RD   = 3'd3,
    S_WAIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(REG_NUM - 1);
  localparam logic [31:0]       RUN_LIMIT = 32'(RUN_CYCLES);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] idx;
  logic              run_last;
  logic              idx_last;
  logic              beat_done;

  // The exit cycle is itself counted, hence the +1 look-ahead.
  assign run_last  = (cycle_cnt_o + 32'd1) == RUN_LIMIT;
  assign idx_last  = idx == LAST_IDX;
  assign beat_done = dump_valid_o && dump_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    cpu_rst_o = 1'b0;
    cpu_en_o  = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_rst_o = 1'b1;
        if (start_i) state_n = S_CLR;
      end
      S_CLR: begin
        cpu_rst_o = 1'b1;
        busy_o    = 1'b1;
        state_n   = S_RUN;
      end
      S_RUN: begin
        cpu_en_o = 1'b1;
        busy_o   = 1'b1;
        if (run_last || halt_i) state_n = S_RD;
      end
      S_RD: begin
        busy_o  = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (beat_done) state_n = idx_last ? S_DONE : S_RD;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) state_n = S_CLR;
      end
      default: begin
        cpu_rst_o = 1'b1;
        state_n   = S_IDLE;
      end
    endcase
  end

  // Counter, walk index and the held dump beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_o  <= '0;
      idx          <= '0;
      dump_valid_o <= 1'b0;
      dump_idx_o   <= '0;
      dump_data_o  <= '0;
    end else begin
      case (state)
        S_CLR: begin
          cycle_cnt_o <= '0;
          idx         <= '0;
        end
        S_RUN: begin
          cycle_cnt_o <= cycle_cnt_o + 32'd1;
        end
        S_RD: begin
          dump_data_o  <= rf_rdata_i;
          dump_idx_o   <= idx;
          dump_valid_o <= 1'b1;
        end
        S_WAIT: begin
          if (beat_done) begin
            dump_valid_o <= 1'b0;
            if (!idx_last) idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rf_raddr_o = idx;

endmodule

// File: tb/tb_run_dump_ctrl.sv
// tb/tb_run_dump_ctrl.sv - randomized self-checking bench for run_dump_ctrl
// Reference: expected run length from halt/budget arithmetic, expected beats from the register array.

module tb_run_dump_ctrl;

  localparam int RUN_CYCLES = 100;
  localparam int REG_NUM    = 32;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              halt_i;
  logic              cpu_rst_o;
  logic              cpu_en_o;
  logic [ADDR_W-1:0] rf_raddr_o;
  logic [DATA_W-1:0] rf_rdata_i;
  logic              dump_valid_o;
  logic              dump_ready_i;
  logic [ADDR_W-1:0] dump_idx_o;
  logic [DATA_W-1:0] dump_data_o;
  logic [31:0]       cycle_cnt_o;
  logic              busy_o;
  logic              done_o;

  logic [DATA_W-1:0] regs [REG_NUM];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  assign rf_rdata_i = regs[rf_raddr_o];

  run_dump_ctrl #(
    .RUN_CYCLES(RUN_CYCLES), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .cpu_rst_o(cpu_rst_o), .cpu_en_o(cpu_en_o),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o),
    .cycle_cnt_o(cycle_cnt_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_regs();
    for (int i = 0; i < REG_NUM; i++) regs[i] = $urandom;
  endtask

  // Entered and left on a falling edge; halt_at=0 means no halt.
  task automatic run_case(input int halt_at, input int stall_idx, input int stall_len,
                          input bit rand_ready, input bit start_mid);
    int en_cnt, cyc, exit_cyc, done_cyc, first_en, first_valid, stall_left, exp_len;
    bit en_prev, gap, pend;
    logic [ADDR_W-1:0] p_idx;
    logic [DATA_W-1:0] p_data;
    int q_idx[$];
    logic [DATA_W-1:0] q_data[$];
    logic [31:0] final_cnt;

    fill_regs();
    en_cnt = 0; cyc = 0; exit_cyc = -1; done_cyc = -1; first_en = -1; first_valid = -1;
    stall_left = stall_len; en_prev = 0; gap = 0; pend = 0; p_idx = '0; p_data = '0;
    dump_ready_i = 1'b1;

    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("clr_rst", {63'd0, cpu_rst_o}, 64'd1);
    check_eq("clr_busy", {63'd0, busy_o}, 64'd1);
    check_eq("clr_en", {63'd0, cpu_en_o}, 64'd0);

    while (!done_o && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      halt_i  = 1'b0;
      start_i = 1'b0;
      if (cpu_en_o) begin
        if (en_cnt > 0 && !en_prev) gap = 1;
        if (en_cnt == 0) first_en = cyc;
        en_cnt++;
        check_eq("run_cnt", 64'(cycle_cnt_o), 64'(en_cnt - 1));
        check_eq("run_rst", {63'd0, cpu_rst_o}, 64'd0);
        if (en_cnt == halt_at) halt_i = 1'b1;
        if (start_mid && en_cnt == 5) start_i = 1'b1;
      end else if (en_prev && exit_cyc < 0) begin
        exit_cyc = cyc;
      end
      en_prev = cpu_en_o;

      if (pend) begin
        check_eq("hold_valid", {63'd0, dump_valid_o}, 64'd1);
        check_eq("hold_idx", 64'(dump_idx_o), 64'(p_idx));
        check_eq("hold_data", 64'(dump_data_o), 64'(p_data));
      end

      if (dump_valid_o && int'(dump_idx_o) == stall_idx && stall_left > 0) begin
        dump_ready_i = 1'b0;
        stall_left--;
      end else begin
        dump_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      if (dump_valid_o) begin
        if (first_valid < 0) first_valid = cyc;
        if (dump_ready_i) begin
          q_idx.push_back(int'(dump_idx_o));
          q_data.push_back(dump_data_o);
        end
        pend   = !dump_ready_i;
        p_idx  = dump_idx_o;
        p_data = dump_data_o;
      end else begin
        pend = 0;
      end
      if (done_o) done_cyc = cyc;
    end

    exp_len = (halt_at > 0 && halt_at < RUN_CYCLES) ? halt_at : RUN_CYCLES;
    check_eq("reach_done", {63'd0, done_o}, 64'd1);
    check_eq("clr_one_cycle", 64'(first_en), 64'd1);
    check_eq("en_cycles", 64'(en_cnt), 64'(exp_len));
    check_eq("en_contiguous", {63'd0, gap}, 64'd0);
    check_eq("final_cnt", 64'(cycle_cnt_o), 64'(exp_len));
    check_eq("beat_count", 64'(q_idx.size()), 64'(REG_NUM));
    for (int i = 0; i < REG_NUM && i < q_idx.size(); i++) begin
      check_eq($sformatf("beat%0d_idx", i), 64'(q_idx[i]), 64'(i));
      check_eq($sformatf("beat%0d_data", i), 64'(q_data[i]), 64'(regs[i]));
    end
    if (!rand_ready && stall_len == 0) begin
      check_eq("first_valid_lat", 64'(first_valid - exit_cyc), 64'd1);
      check_eq("done_lat", 64'(done_cyc - exit_cyc), 64'(2 * REG_NUM));
    end

    final_cnt = cycle_cnt_o;
    dump_ready_i = 1'b1;
    @(negedge clk_i);
    check_eq("done_hold", {63'd0, done_o}, 64'd1);
    check_eq("done_busy", {63'd0, busy_o}, 64'd0);
    check_eq("done_rst", {63'd0, cpu_rst_o}, 64'd0);
    check_eq("done_en", {63'd0, cpu_en_o}, 64'd0);
    check_eq("done_cnt_held", 64'(cycle_cnt_o), 64'(final_cnt));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cpu_rst"}, {63'd0, cpu_rst_o}, 64'd1);
    check_eq({tag, "_cpu_en"}, {63'd0, cpu_en_o}, 64'd0);
    check_eq({tag, "_valid"}, {63'd0, dump_valid_o}, 64'd0);
    check_eq({tag, "_cnt"}, 64'(cycle_cnt_o), 64'd0);
    check_eq({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    check_eq({tag, "_done"}, {63'd0, done_o}, 64'd0);
    check_eq({tag, "_idx"}, 64'(dump_idx_o), 64'd0);
    check_eq({tag, "_raddr"}, 64'(rf_raddr_o), 64'd0);
  endtask

  initial begin
    int cyc;
    bit hit;
    rst_i = 1'b1; start_i = 1'b0; halt_i = 1'b0; dump_ready_i = 1'b1;
    fill_regs();
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_state("por");
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("idle_stays", {63'd0, busy_o}, 64'd0);

    run_case(0, -1, 0, 0, 0);
    run_case(10, -1, 0, 0, 0);
    run_case(RUN_CYCLES, -1, 0, 0, 0);
    run_case(1, -1, 0, 0, 0);
    run_case(0, 3, 5, 0, 0);

    // Reset while beat 7 is waiting on the sink.
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    hit = 0;
    cyc = 0;
    while (!hit && cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      if (dump_valid_o && dump_idx_o == 7) begin
        dump_ready_i = 1'b0;
        rst_i = 1'b1;
        hit = 1;
      end
    end
    check_eq("reach_idx7", {63'd0, hit}, 64'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    dump_ready_i = 1'b1;
    check_reset_state("wait_rst");

    run_case(0, -1, 0, 0, 0);
    run_case(0, -1, 0, 0, 1);

    for (int r = 0; r < 5; r++) begin
      run_case(int'($urandom_range(1, 130)), int'($urandom_range(0, REG_NUM - 1)),
               int'($urandom_range(0, 4)), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
